// File: rtl/sccb_master_if.sv
`default_nettype none
// ============================================================================
// Module      : sccb_master_if
// Description : Request/response and open-drain pad signals of sccb_master.
// Revision    : 1.0 - initial release
// ============================================================================
interface sccb_master_if;
    logic       start;
    logic       writeNotRead;
    logic [6:0] deviceAddress;
    logic [7:0] registerAddress;
    logic [7:0] writeData;
    logic       busy;
    logic       done;
    logic       ackError;
    logic [7:0] readData;
    logic       SCL;
    logic       sdaDriven;
    logic       sdaIn;

    modport master (
        input  start, writeNotRead, deviceAddress, registerAddress, writeData, sdaIn,
        output busy, done, ackError, readData, SCL, sdaDriven
    );

    modport slave (
        output start, writeNotRead, deviceAddress, registerAddress, writeData, sdaIn,
        input  busy, done, ackError, readData, SCL, sdaDriven
    );
endinterface
`default_nettype wire

// File: rtl/sccb_master.sv
`default_nettype none
// ============================================================================
// Module      : sccb_master
// Description : Single-transaction SCCB master (write, or two-phase read).
//               Optional NACK abort enabled by macro SCCB_ACK_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module sccb_master #(
    parameter int CLOCK_FREQUENCY = 74250000,
    parameter int SCCB_FREQUENCY  = 100000
) (
    input  logic          systemClock,
    input  logic          systemReset,
    sccb_master_if.master bus
);
    localparam int QUARTER = CLOCK_FREQUENCY / (4 * SCCB_FREQUENCY);
    localparam int QW      = (QUARTER > 1) ? $clog2(QUARTER) : 1;
    localparam logic [QW-1:0] C_Q_LAST = QW'(QUARTER - 1);

    generate
        if (QUARTER < 4) begin : g_quarter_check
            $error("sccb_master: CLOCK_FREQUENCY / (4*SCCB_FREQUENCY) must be >= 4");
        end
    endgenerate

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_TXBIT = 3'd2;
    localparam logic [2:0] S_TXACK = 3'd3;
    localparam logic [2:0] S_RXBIT = 3'd4;
    localparam logic [2:0] S_MNACK = 3'd5;
    localparam logic [2:0] S_STOP  = 3'd6;
    localparam logic [2:0] S_DONE  = 3'd7;

    logic [2:0]    r_state;
    logic [QW-1:0] r_qcnt;
    logic [1:0]    r_quarter;
    logic [2:0]    r_bit;
    logic [1:0]    r_byte;
    logic          r_phase2;
    logic          r_wnr;
    logic [6:0]    r_dev;
    logic [7:0]    r_reg;
    logic [7:0]    r_wdata;
    logic [7:0]    r_tx;
    logic [7:0]    r_rx;
    logic [7:0]    r_read_data;
    logic          r_sda_meta;
    logic          r_sda_sync;

    logic          w_q_end;
    logic          w_sample;
    logic          w_cell_end;
    logic          w_nack;
    logic [1:0]    w_load_idx;
    logic [7:0]    w_load_byte;
    logic          w_scl;
    logic          w_sda_high;

    assign w_q_end    = (r_qcnt == C_Q_LAST);
    assign w_sample   = w_q_end && (r_quarter == 2'd2);
    assign w_cell_end = w_q_end && (r_quarter == 2'd3);

    // Byte to shift out next: index 0 when leaving START, otherwise the one after r_byte.
    always_comb begin
        w_load_idx  = (r_state == S_TXACK) ? (r_byte + 2'd1) : 2'd0;
        w_load_byte = r_wdata;
        if (r_phase2) begin
            w_load_byte = {r_dev, 1'b1};
        end else begin
            case (w_load_idx)
                2'd0:    w_load_byte = {r_dev, 1'b0};
                2'd1:    w_load_byte = r_reg;
                default: w_load_byte = r_wdata;
            endcase
        end
    end

`ifdef SCCB_ACK_CHECK_EN
    logic r_ack_sample;
    logic r_ack_error;

    always_ff @(posedge systemClock) begin
        if (systemReset) begin
            r_ack_sample <= 1'b0;
            r_ack_error  <= 1'b0;
        end else begin
            if (r_state == S_IDLE && bus.start) begin
                r_ack_sample <= 1'b0;
                r_ack_error  <= 1'b0;
            end else if (r_state == S_TXACK && w_sample) begin
                r_ack_sample <= r_sda_sync;
            end
            if (r_state == S_TXACK && w_cell_end && r_ack_sample) begin
                r_ack_error <= 1'b1;
            end
        end
    end

    assign w_nack       = r_ack_sample;
    assign bus.ackError = r_ack_error;
`else
    assign w_nack       = 1'b0;
    assign bus.ackError = 1'b0;
`endif

    always_ff @(posedge systemClock) begin
        if (systemReset) begin
            r_state     <= S_IDLE;
            r_qcnt      <= '0;
            r_quarter   <= 2'd0;
            r_bit       <= 3'd0;
            r_byte      <= 2'd0;
            r_phase2    <= 1'b0;
            r_wnr       <= 1'b0;
            r_dev       <= 7'd0;
            r_reg       <= 8'd0;
            r_wdata     <= 8'd0;
            r_tx        <= 8'd0;
            r_rx        <= 8'd0;
            r_read_data <= 8'd0;
            r_sda_meta  <= 1'b1;
            r_sda_sync  <= 1'b1;
        end else begin
            r_sda_meta <= bus.sdaIn;
            r_sda_sync <= r_sda_meta;

            if (r_state == S_IDLE || r_state == S_DONE) begin
                r_qcnt    <= '0;
                r_quarter <= 2'd0;
            end else if (w_q_end) begin
                r_qcnt    <= '0;
                r_quarter <= r_quarter + 2'd1;
            end else begin
                r_qcnt <= r_qcnt + QW'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_wnr    <= bus.writeNotRead;
                        r_dev    <= bus.deviceAddress;
                        r_reg    <= bus.registerAddress;
                        r_wdata  <= bus.writeData;
                        r_byte   <= 2'd0;
                        r_phase2 <= 1'b0;
                        r_state  <= S_START;
                    end
                end
                S_START: begin
                    if (w_cell_end) begin
                        r_tx    <= w_load_byte;
                        r_bit   <= 3'd0;
                        r_state <= S_TXBIT;
                    end
                end
                S_TXBIT: begin
                    if (w_cell_end) begin
                        r_tx <= {r_tx[6:0], 1'b0};
                        if (r_bit == 3'd7) begin
                            r_state <= S_TXACK;
                        end else begin
                            r_bit <= r_bit + 3'd1;
                        end
                    end
                end
                S_TXACK: begin
                    if (w_cell_end) begin
                        if (w_nack) begin
                            r_state <= S_STOP;
                        end else if (r_phase2) begin
                            r_bit   <= 3'd0;
                            r_state <= S_RXBIT;
                        end else if (r_byte == 2'd2 || (r_byte == 2'd1 && !r_wnr)) begin
                            r_state <= S_STOP;
                        end else begin
                            r_byte  <= r_byte + 2'd1;
                            r_tx    <= w_load_byte;
                            r_bit   <= 3'd0;
                            r_state <= S_TXBIT;
                        end
                    end
                end
                S_RXBIT: begin
                    if (w_sample) begin
                        r_rx <= {r_rx[6:0], r_sda_sync};
                    end
                    if (w_cell_end) begin
                        if (r_bit == 3'd7) begin
                            r_state <= S_MNACK;
                        end else begin
                            r_bit <= r_bit + 3'd1;
                        end
                    end
                end
                S_MNACK: begin
                    if (w_cell_end) begin
                        r_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (w_cell_end) begin
                        // A read turns around here: second START re-addresses the slave for reading.
                        if (!r_wnr && !r_phase2 && !w_nack) begin
                            r_phase2 <= 1'b1;
                            r_byte   <= 2'd0;
                            r_state  <= S_START;
                        end else begin
                            if (!r_wnr && r_phase2 && !w_nack) begin
                                r_read_data <= r_rx;
                            end
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_scl      = 1'b1;
        w_sda_high = 1'b1;
        case (r_state)
            S_START: begin
                w_scl      = 1'b1;
                w_sda_high = ~r_quarter[1];
            end
            S_TXBIT: begin
                w_scl      = r_quarter[1];
                w_sda_high = r_tx[7];
            end
            S_TXACK, S_RXBIT, S_MNACK: begin
                w_scl      = r_quarter[1];
                w_sda_high = 1'b1;
            end
            S_STOP: begin
                w_scl      = (r_quarter != 2'd0);
                w_sda_high = (r_quarter == 2'd3);
            end
            default: begin
                w_scl      = 1'b1;
                w_sda_high = 1'b1;
            end
        endcase
    end

    assign bus.SCL       = w_scl;
    assign bus.sdaDriven = ~w_sda_high;
    assign bus.busy      = (r_state != S_IDLE) && (r_state != S_DONE);
    assign bus.done      = (r_state == S_DONE);
    assign bus.readData  = r_read_data;

endmodule
`default_nettype wire
